// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Packet-level round-robin arbiter sharing the UART tx FIFO write port
//   among P_NUM_REQ byte-stream requesters. A grant lasts one whole packet,
//   optionally preceded by a source-ID header byte (P_HDR_BASE + index).
//   A grant is force-released after P_MAX_PKT_LEN payload beats without
//   a last byte, flagged by a one-cycle o_trunc_err pulse.
//
// Ports
//   i_sys_clk, i_sys_rst_n   clock, async active-low reset
//   i_req_data/valid/last    per-requester byte stream (k-th slice per requester)
//   o_req_ready              per-requester ready, one-hot or zero
//   o_tx_data/o_tx_write_en  tx FIFO write port, i_tx_full backpressure
//   o_busy                   high while a packet (header or payload) is active
//   o_grant_id               current / last granted requester
//   o_trunc_err              pulse after a length-limit release
module uart_tx_arbiter #(
  parameter int unsigned                P_NUM_REQ     = 4,
  parameter int unsigned                P_DATA_BITS   = 8,
  parameter bit                         P_HDR_EN      = 1'b1,
  parameter logic [P_DATA_BITS-1:0]     P_HDR_BASE    = P_DATA_BITS'('hA0),
  parameter int unsigned                P_MAX_PKT_LEN = 64,
  localparam int unsigned               GW            = $clog2(P_NUM_REQ),
  localparam int unsigned               CW            = $clog2(P_MAX_PKT_LEN + 1)
) (
  input  logic                            i_sys_clk,
  input  logic                            i_sys_rst_n,
  input  logic [P_NUM_REQ*P_DATA_BITS-1:0] i_req_data,
  input  logic [P_NUM_REQ-1:0]            i_req_valid,
  input  logic [P_NUM_REQ-1:0]            i_req_last,
  output logic [P_NUM_REQ-1:0]            o_req_ready,
  output logic [P_DATA_BITS-1:0]          o_tx_data,
  output logic                            o_tx_write_en,
  input  logic                            i_tx_full,
  output logic                            o_busy,
  output logic [GW-1:0]                   o_grant_id,
  output logic                            o_trunc_err
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_STREAM} state_e;

  state_e                                  state_q, state_d;
  logic [GW-1:0]                           grant_q, grant_d;
  logic [GW-1:0]                           rr_q, rr_d;
  logic [CW-1:0]                           cnt_q, cnt_d;
  logic                                    trunc_q, trunc_d;

  logic [P_NUM_REQ-1:0][P_DATA_BITS-1:0]   req_data;
  logic                                    pick_found;
  logic [GW-1:0]                           pick_idx;
  logic [GW-1:0]                           ptr_next;
  logic [CW-1:0]                           cnt_inc;
  logic [P_DATA_BITS-1:0]                  hdr_byte;
  logic                                    beat;

  assign req_data = i_req_data;

  // First valid requester at or after rr_q, wrapping. Walking offsets from
  // the far end down lets the smallest offset win the last assignment.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = int'(P_NUM_REQ) - 1; i >= 0; i--) begin
      int idx;
      idx = int'(rr_q) + i;
      if (idx >= int'(P_NUM_REQ)) idx = idx - int'(P_NUM_REQ);
      if (i_req_valid[idx]) begin
        pick_found = 1'b1;
        pick_idx   = GW'(idx);
      end
    end
  end

  assign ptr_next = (grant_q == GW'(P_NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
  assign cnt_inc  = cnt_q + 1'b1;
  assign hdr_byte = P_HDR_BASE + P_DATA_BITS'(grant_q);
  assign beat     = (state_q == S_STREAM) && i_req_valid[grant_q] && !i_tx_full;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_d          = rr_q;
    cnt_d         = cnt_q;
    trunc_d       = 1'b0;
    o_req_ready   = '0;
    o_tx_write_en = 1'b0;
    o_tx_data     = '0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = P_HDR_EN ? S_HDR : S_STREAM;
        end
      end
      S_HDR: begin
        o_tx_data     = hdr_byte;
        o_tx_write_en = !i_tx_full;
        if (!i_tx_full) state_d = S_STREAM;
      end
      S_STREAM: begin
        o_req_ready[grant_q] = !i_tx_full;
        o_tx_data            = req_data[grant_q];
        o_tx_write_en        = i_req_valid[grant_q] && !i_tx_full;
        if (beat) begin
          cnt_d = cnt_inc;
          // last wins over the length limit: last on the final allowed
          // beat is a normal completion
          if (i_req_last[grant_q]) begin
            state_d = S_IDLE;
            rr_d    = ptr_next;
          end else if (cnt_inc == CW'(P_MAX_PKT_LEN)) begin
            trunc_d = 1'b1;
            state_d = S_IDLE;
            rr_d    = ptr_next;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

  assign o_busy      = (state_q != S_IDLE);
  assign o_grant_id  = grant_q;
  assign o_trunc_err = trunc_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_last = '0;
  logic        tx_full = 1'b0;

  // A: defaults, B: max length 4, C: header disabled
  logic [3:0] a_ready, b_ready, c_ready;
  logic [7:0] a_data, b_data, c_data;
  logic       a_we, b_we, c_we;
  logic       a_busy, b_busy, c_busy;
  logic [1:0] a_gid, b_gid, c_gid;
  logic       a_trunc, b_trunc, c_trunc;

  int checks = 0;
  int errors = 0;

  logic       log_en = 1'b0;
  logic [7:0] wlog[$];

  always #5 clk = ~clk;

  uart_tx_arbiter u_a (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_req_data(req_data),
    .i_req_valid(req_valid), .i_req_last(req_last), .o_req_ready(a_ready),
    .o_tx_data(a_data), .o_tx_write_en(a_we), .i_tx_full(tx_full),
    .o_busy(a_busy), .o_grant_id(a_gid), .o_trunc_err(a_trunc));

  uart_tx_arbiter #(.P_MAX_PKT_LEN(4)) u_b (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_req_data(req_data),
    .i_req_valid(req_valid), .i_req_last(req_last), .o_req_ready(b_ready),
    .o_tx_data(b_data), .o_tx_write_en(b_we), .i_tx_full(tx_full),
    .o_busy(b_busy), .o_grant_id(b_gid), .o_trunc_err(b_trunc));

  uart_tx_arbiter #(.P_HDR_EN(1'b0)) u_c (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_req_data(req_data),
    .i_req_valid(req_valid), .i_req_last(req_last), .o_req_ready(c_ready),
    .o_tx_data(c_data), .o_tx_write_en(c_we), .i_tx_full(tx_full),
    .o_busy(c_busy), .o_grant_id(c_gid), .o_trunc_err(c_trunc));

  // record every FIFO write of instance A while enabled
  always @(posedge clk) if (log_en && a_we) wlog.push_back(a_data);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [7:0] d, input logic v, input logic l);
    req_data[k*8 +: 8] = d;
    req_valid[k]       = v;
    req_last[k]        = l;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_data  = '0;
    req_valid = '0;
    req_last  = '0;
    tx_full   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    // reset state
    #2;
    chk("rst_busy", a_busy, 0);
    chk("rst_gid", a_gid, 0);
    chk("rst_trunc", a_trunc, 0);
    chk("rst_ready", a_ready, 0);
    chk("rst_we", a_we, 0);
    chk("rst_data", a_data, 0);
    do_reset();

    // single packet from requester 1: A1 11 22 33
    set_req(1, 8'h11, 1, 0); #1;
    chk("t1_idle_we", a_we, 0);
    chk("t1_idle_ready", a_ready, 0);
    tick();
    chk("t1_hdr_data", a_data, 8'hA1);
    chk("t1_hdr_we", a_we, 1);
    chk("t1_hdr_gid", a_gid, 1);
    chk("t1_hdr_busy", a_busy, 1);
    chk("t1_hdr_ready", a_ready, 0);
    tick();
    chk("t1_b1_data", a_data, 8'h11);
    chk("t1_b1_we", a_we, 1);
    chk("t1_b1_ready", a_ready, 4'b0010);
    tick(); set_req(1, 8'h22, 1, 0); #1;
    chk("t1_b2_data", a_data, 8'h22);
    chk("t1_b2_we", a_we, 1);
    tick(); set_req(1, 8'h33, 1, 1); #1;
    chk("t1_b3_data", a_data, 8'h33);
    chk("t1_b3_we", a_we, 1);
    chk("t1_b3_trunc", a_trunc, 0);
    tick(); set_req(1, 8'h00, 0, 0); #1;
    chk("t1_end_busy", a_busy, 0);
    chk("t1_end_we", a_we, 0);
    chk("t1_end_trunc", a_trunc, 0);
    chk("t1_end_gid", a_gid, 1);

    // round robin between requesters 0 and 2, 2-byte packets
    do_reset();
    set_req(0, 8'h01, 1, 0);
    set_req(2, 8'h21, 1, 0);
    tick();
    chk("rr_p1_hdr", a_data, 8'hA0);
    chk("rr_p1_gid", a_gid, 0);
    tick();
    chk("rr_p1_b1", a_data, 8'h01);
    chk("rr_p1_ready", a_ready, 4'b0001);
    tick(); set_req(0, 8'h02, 1, 1); #1;
    chk("rr_p1_b2", a_data, 8'h02);
    tick(); set_req(0, 8'h01, 1, 0); #1;
    chk("rr_gap1_busy", a_busy, 0);
    chk("rr_gap1_we", a_we, 0);
    tick();
    chk("rr_p2_hdr", a_data, 8'hA2);
    chk("rr_p2_gid", a_gid, 2);
    chk("rr_p2_hdr_we", a_we, 1);
    tick();
    chk("rr_p2_b1", a_data, 8'h21);
    chk("rr_p2_ready", a_ready, 4'b0100);
    tick(); set_req(2, 8'h22, 1, 1); #1;
    chk("rr_p2_b2", a_data, 8'h22);
    tick(); set_req(2, 8'h21, 1, 0); #1;
    chk("rr_gap2_busy", a_busy, 0);
    tick();
    chk("rr_p3_hdr", a_data, 8'hA0);
    chk("rr_p3_gid", a_gid, 0);
    tick();
    chk("rr_p3_b1", a_data, 8'h01);
    tick(); set_req(0, 8'h02, 1, 1); #1;
    chk("rr_p3_b2", a_data, 8'h02);
    tick(); set_req(0, 8'h00, 0, 0); #1;
    chk("rr_gap3_busy", a_busy, 0);
    tick();
    chk("rr_p4_hdr", a_data, 8'hA2);
    chk("rr_p4_gid", a_gid, 2);
    set_req(2, 8'h00, 0, 0);

    // backpressure: full for 5 cycles on beat 2 of 4
    do_reset();
    wlog.delete();
    log_en = 1'b1;
    set_req(1, 8'h41, 1, 0);
    tick();
    chk("bp_hdr", a_data, 8'hA1);
    tick();
    chk("bp_b1", a_data, 8'h41);
    tick(); set_req(1, 8'h42, 1, 0); tx_full = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_full_we", a_we, 0);
      chk("bp_full_ready", a_ready, 0);
      tick();
    end
    tx_full = 1'b0; #1;
    chk("bp_b2", a_data, 8'h42);
    chk("bp_b2_we", a_we, 1);
    chk("bp_b2_ready", a_ready, 4'b0010);
    tick(); set_req(1, 8'h43, 1, 0); #1;
    chk("bp_b3", a_data, 8'h43);
    tick(); set_req(1, 8'h44, 1, 1); #1;
    chk("bp_b4", a_data, 8'h44);
    tick(); set_req(1, 8'h00, 0, 0); #1;
    chk("bp_end_busy", a_busy, 0);
    log_en = 1'b0;
    chk("bp_nwrites", wlog.size(), 5);
    if (wlog.size() == 5) begin
      chk("bp_w0", wlog[0], 8'hA1);
      chk("bp_w1", wlog[1], 8'h41);
      chk("bp_w2", wlog[2], 8'h42);
      chk("bp_w3", wlog[3], 8'h43);
      chk("bp_w4", wlog[4], 8'h44);
    end

    // truncation on instance B (max 4 beats)
    do_reset();
    set_req(3, 8'h31, 1, 0);
    tick();
    chk("tr_hdr", b_data, 8'hA3);
    chk("tr_gid", b_gid, 3);
    set_req(0, 8'h01, 1, 1);
    tick();
    chk("tr_b1", b_data, 8'h31);
    chk("tr_b1_we", b_we, 1);
    tick(); set_req(3, 8'h32, 1, 0); #1;
    chk("tr_b2", b_data, 8'h32);
    tick(); set_req(3, 8'h33, 1, 0); #1;
    chk("tr_b3", b_data, 8'h33);
    tick(); set_req(3, 8'h34, 1, 0); #1;
    chk("tr_b4", b_data, 8'h34);
    chk("tr_b4_we", b_we, 1);
    chk("tr_b4_trunc", b_trunc, 0);
    tick(); set_req(3, 8'h35, 1, 0); #1;
    chk("tr_pulse", b_trunc, 1);
    chk("tr_idle_busy", b_busy, 0);
    chk("tr_idle_we", b_we, 0);
    tick();
    chk("tr_pulse_end", b_trunc, 0);
    chk("tr_next_gid", b_gid, 0);
    chk("tr_next_hdr", b_data, 8'hA0);

    // async reset mid-packet
    do_reset();
    set_req(1, 8'h51, 1, 0);
    tick();
    tick();
    chk("rm_b1", a_data, 8'h51);
    tick(); set_req(1, 8'h52, 1, 0); #1;
    chk("rm_b2", a_data, 8'h52);
    tick(); set_req(1, 8'h53, 1, 0); #1;
    rst_n = 1'b0; #1;
    chk("rm_busy", a_busy, 0);
    chk("rm_we", a_we, 0);
    chk("rm_ready", a_ready, 0);
    chk("rm_gid", a_gid, 0);
    chk("rm_data", a_data, 0);
    chk("rm_trunc", a_trunc, 0);
    set_req(1, 8'h00, 0, 0);
    set_req(2, 8'h61, 1, 0);
    tick();
    rst_n = 1'b1; #1;
    chk("rm_rel_busy", a_busy, 0);
    tick();
    chk("rm_new_hdr", a_data, 8'hA2);
    chk("rm_new_gid", a_gid, 2);
    chk("rm_new_we", a_we, 1);

    // header disabled, instance C
    do_reset();
    set_req(0, 8'h55, 1, 1); #1;
    chk("nh_idle_we", c_we, 0);
    tick();
    chk("nh_data", c_data, 8'h55);
    chk("nh_we", c_we, 1);
    chk("nh_ready", c_ready, 4'b0001);
    tick(); set_req(0, 8'h00, 0, 0); #1;
    chk("nh_end_busy", c_busy, 0);
    chk("nh_end_we", c_we, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
